// File: rtl/tmmu_dot_stream.sv
// Streaming FP16 dot-product engine: LANES multipliers, pipelined adder tree,
// per-vector accumulator and a credit-controlled result FIFO.
package tmmu_fp16_pkg;

  // FP16 multiply, round-to-nearest-even; subnormal inputs/outputs flush to zero.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [21:0] p;
    logic [10:0] m;
    logic [11:0] mr;
    logic        g, st;
    int          e;
    logic [15:0] r;
    s      = a[15] ^ b[15];
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    p  = '0;
    m  = '0;
    mr = '0;
    g  = 1'b0;
    st = 1'b0;
    e  = 0;
    r  = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      r = 16'h7E00;
    end else if (a_inf || b_inf) begin
      r = {s, 5'h1f, 10'd0};
    end else if (a_zero || b_zero) begin
      r = {s, 15'd0};
    end else begin
      p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
      e = 32'(a[14:10]) + 32'(b[14:10]) - 15;
      if (p[21]) begin
        m  = p[21:11];
        g  = p[10];
        st = |p[9:0];
        e  = e + 1;
      end else begin
        m  = p[20:10];
        g  = p[9];
        st = |p[8:0];
      end
      mr = {1'b0, m} + {11'd0, g && (st || m[0])};
      if (mr[11]) begin
        mr = mr >> 1;
        e  = e + 1;
      end
      if (e >= 31)     r = {s, 5'h1f, 10'd0};
      else if (e <= 0) r = {s, 15'd0};
      else             r = {s, 5'(e), mr[9:0]};
    end
    return r;
  endfunction

  // FP16 add with guard/round/sticky alignment, round-to-nearest-even, flush-to-zero.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, r;
    logic [13:0] mx, my, mal, m14;
    logic [14:0] s15;
    logic [11:0] mr;
    logic        rnd, sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    int unsigned d;
    int          e;
    a_zero = (a[14:10] == 5'd0);
    b_zero = (b[14:10] == 5'd0);
    a_inf  = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    a_nan  = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    x   = a;
    y   = b;
    mx  = '0;
    my  = '0;
    mal = '0;
    m14 = '0;
    s15 = '0;
    mr  = '0;
    rnd = 1'b0;
    sgn = 1'b0;
    d   = 0;
    e   = 0;
    r   = '0;
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      r = 16'h7E00;
    end else if (a_inf) begin
      r = {a[15], 5'h1f, 10'd0};
    end else if (b_inf) begin
      r = {b[15], 5'h1f, 10'd0};
    end else if (a_zero && b_zero) begin
      r = {a[15] & b[15], 15'd0};
    end else if (a_zero) begin
      r = b;
    end else if (b_zero) begin
      r = a;
    end else begin
      if (a[14:0] < b[14:0]) begin
        x = b;
        y = a;
      end
      d   = 32'(x[14:10]) - 32'(y[14:10]);
      mx  = {1'b1, x[9:0], 3'b000};
      my  = {1'b1, y[9:0], 3'b000};
      if (d > 13) mal = 14'd1;
      else        mal = (my >> d) | {13'd0, |(my << (14 - d))};
      e   = 32'(x[14:10]);
      sgn = x[15];
      if (x[15] == y[15]) begin
        s15 = {1'b0, mx} + {1'b0, mal};
        if (s15[14]) begin
          m14 = s15[14:1] | {13'd0, s15[0]};
          e   = e + 1;
        end else begin
          m14 = s15[13:0];
        end
      end else begin
        m14 = mx - mal;
        for (int unsigned i = 0; i < 13; i++) begin
          if (!m14[13]) begin
            m14 = m14 << 1;
            e   = e - 1;
          end
        end
      end
      if (m14 == 14'd0) begin
        r = 16'h0000;
      end else begin
        rnd = m14[2] && ((|m14[1:0]) || m14[3]);
        mr  = {1'b0, m14[13:3]} + {11'd0, rnd};
        if (mr[11]) begin
          mr = mr >> 1;
          e  = e + 1;
        end
        if (e >= 31)     r = {sgn, 5'h1f, 10'd0};
        else if (e <= 0) r = {sgn, 15'd0};
        else             r = {sgn, 5'(e), mr[9:0]};
      end
    end
    return r;
  endfunction

endpackage

module tmmu_flomul (
  input  logic        clk,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  import tmmu_fp16_pkg::*;
  always_ff @(posedge clk) y <= fp16_mul(a, b);
endmodule

module tmmu_floadd (
  input  logic        clk,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  import tmmu_fp16_pkg::*;
  always_ff @(posedge clk) y <= fp16_add(a, b);
endmodule

module tmmu_dot_stream #(
  parameter int WIDTH      = 16,
  parameter int LANES      = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int BEAT_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_w,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [BEAT_W-1:0]      out_beats
);
  localparam int L  = $clog2(LANES);
  localparam int NS = L + 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]       DEPTH_C  = FIFO_DEPTH[CW:0];
  localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

  logic                   fire, first_pending;
  logic [LANES*WIDTH-1:0] a_q, w_q;
  logic [NS-1:0]          sb_valid, sb_last, sb_first;
  logic [WIDTH-1:0]       node [1:2*LANES-1];

  assign fire = in_valid && in_ready;

  always_ff @(posedge clk) begin
    a_q <= in_a;
    w_q <= in_w;
  end

  // Sideband: bit 0 = beat register, bit NS-1 = tree root.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_valid      <= '0;
      sb_last       <= '0;
      sb_first      <= '0;
      first_pending <= 1'b1;
    end else begin
      sb_valid <= {sb_valid[NS-2:0], fire};
      sb_last  <= {sb_last[NS-2:0], in_last};
      sb_first <= {sb_first[NS-2:0], first_pending};
      if (fire) first_pending <= in_last;
    end
  end

  // Heap-indexed tree: leaves at LANES+i, node n sums children 2n and 2n+1.
  for (genvar i = 0; i < LANES; i++) begin : g_mul
    tmmu_flomul u_mul (
      .clk (clk),
      .a   (a_q[i*WIDTH +: WIDTH]),
      .b   (w_q[i*WIDTH +: WIDTH]),
      .y   (node[LANES+i])
    );
  end
  for (genvar n = 1; n < LANES; n++) begin : g_add
    tmmu_floadd u_add (
      .clk (clk),
      .a   (node[2*n]),
      .b   (node[2*n+1]),
      .y   (node[n])
    );
  end

  logic              acc_valid, acc_last;
  logic [WIDTH-1:0]  acc_q, acc_hold, acc_sel;
  logic [BEAT_W-1:0] acc_beats;

  // acc_q keeps computing during bubbles, so the last valid sum is held separately.
  assign acc_sel = sb_first[NS-1] ? '0 : (acc_valid ? acc_q : acc_hold);

  tmmu_floadd u_acc (
    .clk (clk),
    .a   (acc_sel),
    .b   (node[1]),
    .y   (acc_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_valid <= 1'b0;
      acc_last  <= 1'b0;
      acc_hold  <= '0;
      acc_beats <= '0;
    end else begin
      acc_valid <= sb_valid[NS-1];
      acc_last  <= sb_valid[NS-1] && sb_last[NS-1];
      if (acc_valid) acc_hold <= acc_q;
      if (sb_valid[NS-1]) begin
        if (sb_first[NS-1])            acc_beats <= BEAT_W'(1);
        else if (acc_beats != BEAT_MAX) acc_beats <= acc_beats + BEAT_W'(1);
      end
    end
  end

  logic                      wr_en, pop;
  logic [BEAT_W+WIDTH-1:0]   mem [0:FIFO_DEPTH-1];
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             count, inflight;

  assign wr_en     = acc_valid && acc_last;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
  assign out_beats = out_valid ? mem[rd_ptr][WIDTH +: BEAT_W] : '0;
  assign in_ready  = !reset && (({1'b0, inflight} + {1'b0, count}) < DEPTH_C);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {acc_beats, acc_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      case ({fire && in_last, wr_en})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  a_no_full_write: assert property (@(posedge clk) disable iff (reset)
    !(wr_en && (count == DEPTH_C[CW-1:0])));

endmodule
